// File: rtl/dsp48e2.sv
// Simplified DSP48E2 slice: optional A/B/C input registers, 27x18 signed multiplier,
// W/X/Y/Z operand muxes, SIMD-split arithmetic unit, bitwise logic unit and optional P register.
module dsp48e2 #(
    parameter string USE_MULT = "NONE",
    parameter string USE_SIMD = "ONE48",
    parameter int    AREG     = 0,
    parameter int    BREG     = 0,
    parameter int    CREG     = 0,
    parameter int    PREG     = 0
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTP,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CEP,
    input  logic [29:0] A,
    input  logic [17:0] B,
    input  logic [47:0] C,
    input  logic        CARRYIN,
    input  logic [3:0]  ALUMODE,
    input  logic [8:0]  OPMODE,
    output logic [47:0] P,
    output logic [3:0]  CARRYOUT
);

    localparam bit MULT_EN = (USE_MULT == "MULTIPLY");
    localparam int LW      = (USE_SIMD == "FOUR12") ? 12 : ((USE_SIMD == "TWO24") ? 24 : 48);
    localparam int NLANES  = 48 / LW;

    logic [29:0] a_s;
    logic [17:0] b_s;
    logic [47:0] c_s;
    logic [47:0] p_fb_s;
    logic [44:0] prod_s;
    logic [47:0] m_s, w_s, x_s, y_s, z_s;
    logic [47:0] arith_s, logic_s, res_s;
    logic [3:0]  co_raw_s, res_co_s;
    logic        unused_clk_s;

    assign unused_clk_s = CLK;

    if (AREG == 1) begin : g_areg
        logic [29:0] a_r;
        // A input register, reset has priority over the enable
        always_ff @(posedge CLK) begin
            if (RSTA)     a_r <= 30'd0;
            else if (CEA) a_r <= A;
        end
        assign a_s = a_r;
    end else begin : g_acomb
        logic unused_a_s;
        assign unused_a_s = RSTA ^ CEA;
        assign a_s = A;
    end

    if (BREG == 1) begin : g_breg
        logic [17:0] b_r;
        // B input register, reset has priority over the enable
        always_ff @(posedge CLK) begin
            if (RSTB)     b_r <= 18'd0;
            else if (CEB) b_r <= B;
        end
        assign b_s = b_r;
    end else begin : g_bcomb
        logic unused_b_s;
        assign unused_b_s = RSTB ^ CEB;
        assign b_s = B;
    end

    if (CREG == 1) begin : g_creg
        logic [47:0] c_r;
        // C input register, reset has priority over the enable
        always_ff @(posedge CLK) begin
            if (RSTC)     c_r <= 48'd0;
            else if (CEC) c_r <= C;
        end
        assign c_s = c_r;
    end else begin : g_ccomb
        logic unused_c_s;
        assign unused_c_s = RSTC ^ CEC;
        assign c_s = C;
    end

    assign prod_s = $signed({{18{a_s[26]}}, a_s[26:0]}) * $signed({{27{b_s[17]}}, b_s});
    assign m_s    = MULT_EN ? {{3{prod_s[44]}}, prod_s} : 48'd0;

    // operand muxes; P feedback is forced to zero when there is no P register
    always_comb begin
        x_s = 48'd0;
        y_s = 48'd0;
        z_s = 48'd0;
        w_s = 48'd0;
        case (OPMODE[1:0])
            2'b01:   x_s = m_s;
            2'b10:   x_s = p_fb_s;
            2'b11:   x_s = {a_s, b_s};
            default: x_s = 48'd0;
        endcase
        case (OPMODE[3:2])
            2'b10:   y_s = 48'hFFFF_FFFF_FFFF;
            2'b11:   y_s = c_s;
            default: y_s = 48'd0;
        endcase
        case (OPMODE[6:4])
            3'b010:  z_s = p_fb_s;
            3'b011:  z_s = c_s;
            default: z_s = 48'd0;
        endcase
        case (OPMODE[8:7])
            2'b01:   w_s = p_fb_s;
            2'b11:   w_s = c_s;
            default: w_s = 48'd0;
        endcase
    end

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [LW-1:0] z_l, s_l, op_a, op_b;
        logic          op_c, cin_l;
        logic [LW:0]   sum_l;

        assign cin_l = (l == 0) ? CARRYIN : 1'b0;
        assign z_l   = z_s[l*LW +: LW];
        assign s_l   = w_s[l*LW +: LW] + x_s[l*LW +: LW] + y_s[l*LW +: LW] + LW'(cin_l);

        // all four arithmetic modes share one adder via operand inversion
        always_comb begin
            op_a = z_l;
            op_b = s_l;
            op_c = 1'b0;
            case (ALUMODE)
                4'b0011: begin
                    op_b = ~s_l;
                    op_c = 1'b1;
                end
                4'b0001: op_a = ~z_l;
                default: op_c = 1'b0;
            endcase
        end

        assign sum_l = {1'b0, op_a} + {1'b0, op_b} + (LW+1)'(op_c);
        assign arith_s[l*LW +: LW] = (ALUMODE == 4'b0010) ? ~sum_l[LW-1:0] : sum_l[LW-1:0];
        assign co_raw_s[(l+1)*(LW/12)-1] = sum_l[LW];
    end

    for (genvar k = 0; k < 4; k++) begin : g_co_fill
        if ((((k + 1) * 12) % LW) != 0) begin : g_zero
            assign co_raw_s[k] = 1'b0;
        end
    end

    // bitwise logic unit; Y = all-ones selects the complementary function table
    always_comb begin
        logic inv_s;
        inv_s   = (OPMODE[3:2] == 2'b10);
        logic_s = 48'd0;
        case (ALUMODE)
            4'b0100, 4'b0111: logic_s = inv_s ? ~(x_s ^ z_s) : (x_s ^ z_s);
            4'b0101, 4'b0110: logic_s = inv_s ? (x_s ^ z_s) : ~(x_s ^ z_s);
            4'b1100:          logic_s = inv_s ? (x_s | z_s) : (x_s & z_s);
            4'b1101:          logic_s = inv_s ? (x_s | ~z_s) : (x_s & ~z_s);
            4'b1110:          logic_s = inv_s ? ~(x_s | z_s) : ~(x_s & z_s);
            4'b1111:          logic_s = inv_s ? (~x_s & z_s) : (~x_s | z_s);
            default:          logic_s = 48'd0;
        endcase
    end

    // result select; unlisted ALUMODE codes yield zero
    always_comb begin
        res_s    = 48'd0;
        res_co_s = 4'd0;
        case (ALUMODE)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                res_s    = arith_s;
                res_co_s = co_raw_s;
            end
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: res_s = logic_s;
            default: res_s = 48'd0;
        endcase
    end

    if (PREG == 1) begin : g_preg
        logic [47:0] p_r;
        logic [3:0]  co_r;
        // output register, reset has priority over the enable
        always_ff @(posedge CLK) begin
            if (RSTP) begin
                p_r  <= 48'd0;
                co_r <= 4'd0;
            end else if (CEP) begin
                p_r  <= res_s;
                co_r <= res_co_s;
            end
        end
        assign p_fb_s   = p_r;
        assign P        = p_r;
        assign CARRYOUT = co_r;
    end else begin : g_pcomb
        logic unused_p_s;
        assign unused_p_s = RSTP ^ CEP;
        assign p_fb_s     = 48'd0;
        assign P          = res_s;
        assign CARRYOUT   = res_co_s;
    end

endmodule

// File: tb/tb_dsp48e2.sv
// Self-checking bench for dsp48e2: directed cases from the datasheet examples, then
// randomized traffic on five configurations compared against a behavioural model.
module tb_dsp48e2;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c, rst_p;
    logic        ce_a, ce_b, ce_c, ce_p;
    logic [29:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic        cin;
    logic [3:0]  alumode;
    logic [8:0]  opmode;

    logic [47:0] p_f12, p_t24, p_o48, p_reg, p_acc;
    logic [3:0]  co_f12, co_t24, co_o48, co_reg, co_acc;

    int n_checks = 0;
    int n_errors = 0;

    // reference state for the registered instances
    logic [47:0] mr_p, ma_p, rc_q;
    logic [3:0]  mr_co, ma_co;
    logic [29:0] ra_q;
    logic [17:0] rb_q;
    logic [51:0] nr, na;

    logic [3:0] modes [12] = '{4'b0000, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b0111,
                               4'b0101, 4'b0110, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    always #5 clk = ~clk;

    dsp48e2 #(.USE_MULT("NONE"), .USE_SIMD("FOUR12")) u_f12 (
        .CLK(clk), .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTP(rst_p),
        .CEA(ce_a), .CEB(ce_b), .CEC(ce_c), .CEP(ce_p), .A(a), .B(b), .C(c),
        .CARRYIN(cin), .ALUMODE(alumode), .OPMODE(opmode), .P(p_f12), .CARRYOUT(co_f12));

    dsp48e2 #(.USE_MULT("NONE"), .USE_SIMD("TWO24")) u_t24 (
        .CLK(clk), .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTP(rst_p),
        .CEA(ce_a), .CEB(ce_b), .CEC(ce_c), .CEP(ce_p), .A(a), .B(b), .C(c),
        .CARRYIN(cin), .ALUMODE(alumode), .OPMODE(opmode), .P(p_t24), .CARRYOUT(co_t24));

    dsp48e2 #(.USE_MULT("MULTIPLY"), .USE_SIMD("ONE48")) u_o48 (
        .CLK(clk), .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTP(rst_p),
        .CEA(ce_a), .CEB(ce_b), .CEC(ce_c), .CEP(ce_p), .A(a), .B(b), .C(c),
        .CARRYIN(cin), .ALUMODE(alumode), .OPMODE(opmode), .P(p_o48), .CARRYOUT(co_o48));

    dsp48e2 #(.USE_MULT("MULTIPLY"), .USE_SIMD("ONE48"), .AREG(1), .BREG(1), .CREG(1), .PREG(1)) u_reg (
        .CLK(clk), .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTP(rst_p),
        .CEA(ce_a), .CEB(ce_b), .CEC(ce_c), .CEP(ce_p), .A(a), .B(b), .C(c),
        .CARRYIN(cin), .ALUMODE(alumode), .OPMODE(opmode), .P(p_reg), .CARRYOUT(co_reg));

    dsp48e2 #(.USE_MULT("NONE"), .USE_SIMD("FOUR12"), .PREG(1)) u_acc (
        .CLK(clk), .RSTA(rst_a), .RSTB(rst_b), .RSTC(rst_c), .RSTP(rst_p),
        .CEA(ce_a), .CEB(ce_b), .CEC(ce_c), .CEP(ce_p), .A(a), .B(b), .C(c),
        .CARRYIN(cin), .ALUMODE(alumode), .OPMODE(opmode), .P(p_acc), .CARRYOUT(co_acc));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: returns {CARRYOUT, P} for one evaluation of the slice.
    function automatic logic [51:0] ref_dsp(input int lw, input bit mult,
                                            input logic [29:0] fa, input logic [17:0] fb,
                                            input logic [47:0] fc, input logic [47:0] pfb,
                                            input logic fcin, input logic [3:0] alu,
                                            input logic [8:0] op);
        logic [47:0] m, x, y, z, w, p;
        logic [3:0]  co;
        logic [63:0] mask, zl, sl, r;
        logic        cy, inv;
        longint      prod;
        prod = longint'($signed(fa[26:0])) * longint'($signed(fb));
        m    = mult ? prod[47:0] : 48'd0;
        case (op[1:0])
            2'b00: x = 48'd0;
            2'b01: x = m;
            2'b10: x = pfb;
            default: x = {fa, fb};
        endcase
        case (op[3:2])
            2'b10: y = 48'hFFFF_FFFF_FFFF;
            2'b11: y = fc;
            default: y = 48'd0;
        endcase
        case (op[6:4])
            3'b010: z = pfb;
            3'b011: z = fc;
            default: z = 48'd0;
        endcase
        case (op[8:7])
            2'b01: w = pfb;
            2'b11: w = fc;
            default: w = 48'd0;
        endcase
        p  = 48'd0;
        co = 4'd0;
        if (alu[3:2] == 2'b00) begin
            mask = (64'd1 << lw) - 64'd1;
            for (int l = 0; l < 48 / lw; l++) begin
                zl = (64'(z) >> (l * lw)) & mask;
                sl = ((64'(w) >> (l * lw)) & mask) + ((64'(x) >> (l * lw)) & mask)
                   + ((64'(y) >> (l * lw)) & mask) + ((l == 0) ? 64'(fcin) : 64'd0);
                sl = sl & mask;
                case (alu[1:0])
                    2'b00: begin r = zl + sl;              cy = r[lw];      end
                    2'b11: begin r = zl - sl;              cy = (zl >= sl); end
                    2'b01: begin r = sl - zl - 64'd1;      cy = (sl > zl);  end
                    default: begin r = ~(zl + sl);         cy = r[lw] ^ 1'b1; end
                endcase
                p = p | 48'((r & mask) << (l * lw));
                co[((l + 1) * lw) / 12 - 1] = cy;
            end
        end else if (alu[2]) begin
            inv = (op[3:2] == 2'b10);
            case (alu)
                4'b0100, 4'b0111: p = inv ? ~(x ^ z) : (x ^ z);
                4'b0101, 4'b0110: p = inv ? (x ^ z) : ~(x ^ z);
                4'b1100:          p = inv ? (x | z) : (x & z);
                4'b1101:          p = inv ? (x | ~z) : (x & ~z);
                4'b1110:          p = inv ? ~(x | z) : ~(x & z);
                default:          p = inv ? (~x & z) : (~x | z);
            endcase
        end
        return {co, p};
    endfunction

    initial begin
        {rst_a, rst_b, rst_c, rst_p} = 4'b1111;
        {ce_a, ce_b, ce_c, ce_p}     = 4'b1111;
        a = 30'd0; b = 18'd0; c = 48'd0; cin = 1'b0;
        alumode = 4'd0; opmode = 9'd0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("reset_reg_p", p_reg, 64'd0);
        check_eq("reset_reg_co", co_reg, 64'd0);
        check_eq("reset_acc_p", p_acc, 64'd0);
        check_eq("reset_acc_co", co_acc, 64'd0);
        {rst_a, rst_b, rst_c, rst_p} = 4'b0000;

        // four-lane XOR
        alumode = 4'b0100; opmode = 9'b000110011;
        {a, b} = 48'h00000C00B00A; c = 48'h000003002001; #1;
        check_eq("xor_f12_p", p_f12, 64'h00000F00900B);

        // lane-isolated add across all three SIMD splits
        alumode = 4'b0000; {a, b} = 48'hFFFFFFFFFFFF; c = 48'h001001001001; #1;
        check_eq("add_f12_p", p_f12, 64'd0);
        check_eq("add_f12_co", co_f12, 64'hF);
        check_eq("add_o48_p", p_o48, 64'h001001001000);
        check_eq("add_o48_co", co_o48, 64'h8);
        check_eq("add_t24_p", p_t24, 64'h001000001000);
        check_eq("add_t24_co", co_t24, 64'hA);

        // signed multiply 3 * -2
        opmode = 9'b000000101; a = 30'd3; b = 18'h3FFFE; c = 48'd0; #1;
        check_eq("mul_o48_p", p_o48, 64'hFFFFFFFFFFFA);
        check_eq("mul_o48_co", co_o48, 64'h0);
        check_eq("mul_off_f12_p", p_f12, 64'd0);

        // accumulate through the P register
        rst_p = 1'b1;
        @(posedge clk); #1;
        check_eq("acc_clear", p_acc, 64'd0);
        rst_p = 1'b0; opmode = 9'b000100011; {a, b} = 48'd5; cin = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check_eq("acc_step", p_acc, 64'(5 * i));
        end
        rst_p = 1'b1;
        @(posedge clk); #1;
        check_eq("acc_rst", p_acc, 64'd0);
        rst_p = 1'b0;
        @(posedge clk); #1;
        check_eq("acc_restart", p_acc, 64'd5);
        ce_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("acc_hold", p_acc, 64'd5);
        rst_p = 1'b1;
        @(posedge clk); #1;
        check_eq("acc_rst_over_ce", p_acc, 64'd0);

        // randomized traffic against the model
        {rst_a, rst_b, rst_c, rst_p} = 4'b1111;
        {ce_a, ce_b, ce_c, ce_p}     = 4'b1111;
        @(posedge clk);
        mr_p = 48'd0; mr_co = 4'd0; ma_p = 48'd0; ma_co = 4'd0;
        ra_q = 30'd0; rb_q = 18'd0; rc_q = 48'd0;
        repeat (400) begin
            @(negedge clk);
            a   = 30'($urandom);
            b   = 18'($urandom);
            c   = ($urandom_range(3) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
            if ($urandom_range(3) == 0) {a, b} = 48'hFFFF_FFFF_FFFF;
            cin = 1'($urandom);
            alumode = ($urandom_range(7) == 0) ? 4'($urandom) : modes[$urandom_range(11)];
            opmode  = 9'($urandom);
            if (alumode[2]) opmode[2] = 1'b0;
            ce_a  = ($urandom_range(3) != 0); ce_b = ($urandom_range(3) != 0);
            ce_c  = ($urandom_range(3) != 0); ce_p = ($urandom_range(3) != 0);
            rst_a = ($urandom_range(15) == 0); rst_b = ($urandom_range(15) == 0);
            rst_c = ($urandom_range(15) == 0); rst_p = ($urandom_range(15) == 0);
            #4;
            nr = ref_dsp(12, 1'b0, a, b, c, 48'd0, cin, alumode, opmode);
            check_eq("rnd_f12_p", p_f12, 64'(nr[47:0]));
            check_eq("rnd_f12_co", co_f12, 64'(nr[51:48]));
            nr = ref_dsp(24, 1'b0, a, b, c, 48'd0, cin, alumode, opmode);
            check_eq("rnd_t24_p", p_t24, 64'(nr[47:0]));
            check_eq("rnd_t24_co", co_t24, 64'(nr[51:48]));
            nr = ref_dsp(48, 1'b1, a, b, c, 48'd0, cin, alumode, opmode);
            check_eq("rnd_o48_p", p_o48, 64'(nr[47:0]));
            check_eq("rnd_o48_co", co_o48, 64'(nr[51:48]));
            check_eq("rnd_reg_p", p_reg, 64'(mr_p));
            check_eq("rnd_reg_co", co_reg, 64'(mr_co));
            check_eq("rnd_acc_p", p_acc, 64'(ma_p));
            check_eq("rnd_acc_co", co_acc, 64'(ma_co));
            @(posedge clk);
            nr = ref_dsp(48, 1'b1, ra_q, rb_q, rc_q, mr_p, cin, alumode, opmode);
            na = ref_dsp(12, 1'b0, a, b, c, ma_p, cin, alumode, opmode);
            if (rst_p) begin
                mr_p = 48'd0; mr_co = 4'd0; ma_p = 48'd0; ma_co = 4'd0;
            end else if (ce_p) begin
                {mr_co, mr_p} = nr;
                {ma_co, ma_p} = na;
            end
            ra_q = rst_a ? 30'd0 : (ce_a ? a : ra_q);
            rb_q = rst_b ? 18'd0 : (ce_b ? b : rb_q);
            rc_q = rst_c ? 48'd0 : (ce_c ? c : rc_q);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dsp48e2.md
DSP48E2 -- requirements
Module: dsp48e2

Interface
REQ-001 Parameter USE_MULT, default "NONE"; "NONE" or "MULTIPLY"; enables the 27x18 signed multiplier.
REQ-002 Parameter USE_SIMD, default "ONE48"; "ONE48", "TWO24" or "FOUR12"; selects ALU lane split.
REQ-003 Parameter AREG, default 0; 0 or 1; pipeline stages on A.
REQ-004 Parameter BREG, default 0; 0 or 1; pipeline stages on B.
REQ-005 Parameter CREG, default 0; 0 or 1; pipeline stages on C.
REQ-006 Parameter PREG, default 0; 0 or 1; output register on P and CARRYOUT.
REQ-007 CLK  in  1  sole clock, rising edge.
REQ-008 RSTA, RSTB, RSTC, RSTP  in  1 each  synchronous, active-high resets of the A, B, C and P registers.
REQ-009 CEA, CEB, CEC, CEP  in  1 each  clock enables of the A, B, C and P registers.
REQ-010 A  in  30  A data; B  in  18  B data; C  in  48  C data; CARRYIN  in  1  carry-in.
REQ-011 ALUMODE  in  4  ALU function; OPMODE  in  9  operand select, decoded as W=[8:7], Z=[6:4], Y=[3:2], X=[1:0].
REQ-012 P  out  48  result; CARRYOUT  out  4  per-lane carry.
REQ-013 The design SHALL use one clock; all resets SHALL be synchronous and active-high.

Function
REQ-014 The X mux SHALL select: 00 -> 0; 01 -> M; 10 -> P; 11 -> A:B concatenation, with A in bits [47:18] and B in bits [17:0].
REQ-015 The Y mux SHALL select: 00 -> 0; 01 -> 0 (M is supplied through X); 10 -> 48'hFFFFFFFFFFFF; 11 -> C.
REQ-016 The Z mux SHALL select: 000 -> 0; 010 -> P; 011 -> C; all other codes -> 0.
REQ-017 The W mux SHALL select: 00 -> 0; 01 -> P; 10 -> 0; 11 -> C.
REQ-018 M SHALL be the signed product A[26:0] x B[17:0], sign-extended to 48 bits, when USE_MULT="MULTIPLY"; otherwise M SHALL be 0.
REQ-019 The M operand SHALL be used only with X=01 and Y=01.
REQ-020 USE_MULT="MULTIPLY" SHALL require USE_SIMD="ONE48".
REQ-021 Any mux selecting P while PREG=0 SHALL yield 0, so that no combinational loop exists.
REQ-022 Arithmetic modes, with S = W+X+Y+CARRYIN:
- ALUMODE 0000 -> Z+S
- 0011 -> Z-S
- 0001 -> -Z+S-1
- 0010 -> -(Z+S)-1
REQ-023 Arithmetic SHALL be performed per lane: lane width 48, 24 or 12 bits according to USE_SIMD.
- No carry SHALL propagate across lane boundaries.
- CARRYIN SHALL enter lane 0 only.
REQ-024 CARRYOUT[k] SHALL be the raw adder carry-out of the 12-bit lane ending at bit 12k+11.
- In TWO24 mode, only bits 1 and 3 are valid and bits 0 and 2 SHALL be 0.
- In ONE48 mode, only bit 3 is valid and bits 0-2 SHALL be 0.
REQ-025 Logic modes with OPMODE[3:2]=00, bitwise over 48 bits and independent of SIMD:
- ALUMODE 0100/0111 -> X^Z
- 0101/0110 -> ~(X^Z)
- 1100 -> X&Z
- 1101 -> X&~Z
- 1110 -> ~(X&Z)
- 1111 -> ~X|Z
REQ-026 Logic modes with OPMODE[3:2]=10:
- ALUMODE 0100/0111 -> ~(X^Z)
- 0101/0110 -> X^Z
- 1100 -> X|Z
- 1101 -> X|~Z
- 1110 -> ~(X|Z)
- 1111 -> ~X&Z
REQ-027 In logic modes, CARRYOUT SHALL be 0.
REQ-028 Unlisted ALUMODE codes SHALL produce P=0 and CARRYOUT=0.
REQ-029 With a register parameter at 0, the corresponding path SHALL be combinational.
REQ-030 With a register parameter at 1, the register SHALL load on a rising CLK edge when its CE=1 and SHALL hold when CE=0.
REQ-031 Latency from a data input to P SHALL be max(AREG,BREG,CREG)+PREG cycles for the path used.
REQ-032 Control inputs (ALUMODE, OPMODE, CARRYIN) SHALL be unregistered.

Reset
REQ-033 When RSTx=1 at a rising CLK edge, the corresponding register SHALL load 0, regardless of its CE.
REQ-034 Reset SHALL take priority over CE.
REQ-035 With PREG=1, RSTP SHALL clear P and CARRYOUT to 0 on the next edge.
REQ-036 With PREG=0, P SHALL follow the inputs regardless of reset.
REQ-037 A reset asserted mid-accumulation SHALL discard the accumulated value; accumulation restarts from 0.

Verification
REQ-038 XOR, FOUR12, all REG=0, OPMODE 000110011, ALUMODE 0100, A:B=48'h00000C00B00A, C=48'h000003002001 -> P=48'h00000F00900B in the same cycle.
REQ-039 FOUR12 add, OPMODE 000110011, ALUMODE 0000, A:B=48'hFFFFFFFFFFFF, C=48'h001001001001 -> P=0, CARRYOUT=4'b1111.
REQ-040 ONE48 add, same operands as REQ-039 -> P=48'h001001001000, CARRYOUT=4'b1000.
REQ-041 MULTIPLY, OPMODE 000000101, ALUMODE 0000, A=3, B=18'h3FFFE -> P=48'hFFFFFFFFFFFA.
REQ-042 PREG=1, OPMODE 000100011 (Z=P, X=A:B), A:B=5, CEP=1, RSTP=0 for 3 edges -> P=5, 10, 15 on successive edges.
- Then RSTP=1 for 1 edge -> P=0.
- With CEP=0 -> P holds its value.
